// File: rtl/feature_decoder.sv
// rtl/feature_decoder.sv - 2->4 ReLU / 4->1 linear decoder on one shared 8x8 MAC (option: DECODER_SAT_CNT_EN)
module feature_decoder #(
  parameter int FRAC  = 6,
  parameter int ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] feature0,
  input  logic signed [7:0] feature1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] out_sample,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic signed [7:0] wr_data,
  output logic              busy
`ifdef DECODER_SAT_CNT_EN
  ,
  output logic [7:0]        sat_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HID  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               r_state;
  logic [2:0]               r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [7:0]        r_f0, r_f1;
  logic signed [7:0]        r_h    [0:3];
  logic signed [7:0]        r_coef [0:16];
  logic signed [7:0]        r_out_sample;
  logic                     r_out_valid;

  logic signed [7:0]        w_mul_a, w_mul_b;
  logic signed [15:0]       w_prod;
  logic signed [ACC_W-1:0]  w_sum, w_shift;
  logic                     w_hi, w_lo;
  logic signed [7:0]        w_sat8, w_relu;
  logic [4:0]               w_nb_idx;
  logic                     w_wr_ok;

  function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [7:0] b);
    return {{(ACC_W-8-FRAC){b[7]}}, b, {FRAC{1'b0}}};
  endfunction

  // r_cnt walks {j,k} in HID (8 steps) and j in OUT (4 steps)
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    if (r_state == S_HID) begin
      w_mul_a = r_coef[{2'b00, r_cnt}];
      w_mul_b = r_cnt[0] ? r_f1 : r_f0;
    end else if (r_state == S_OUT) begin
      w_mul_a = r_coef[5'd12 + {3'b000, r_cnt[1:0]}];
      w_mul_b = r_h[r_cnt[1:0]];
    end
  end

  assign w_prod   = w_mul_a * w_mul_b;
  assign w_sum    = r_acc + $signed({{(ACC_W-16){w_prod[15]}}, w_prod});
  assign w_shift  = w_sum >>> FRAC;
  assign w_hi     = w_shift > $signed(ACC_W'(127));
  assign w_lo     = w_shift < $signed(ACC_W'(-128));
  assign w_sat8   = w_hi ? 8'sd127 : (w_lo ? -8'sd128 : w_shift[7:0]);
  assign w_relu   = w_sat8[7] ? 8'sd0 : w_sat8;
  assign w_nb_idx = (r_cnt == 3'd7) ? 5'd16 : (5'd9 + {3'b000, r_cnt[2:1]});
  assign w_wr_ok  = wr_en && (r_state == S_IDLE) && (wr_addr <= 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 17; i++) r_coef[i] <= '0;
    end else if (w_wr_ok) begin
      r_coef[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_f0         <= '0;
      r_f1         <= '0;
      for (int i = 0; i < 4; i++) r_h[i] <= '0;
      r_out_sample <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_f0    <= feature0;
            r_f1    <= feature1;
            r_acc   <= bias_ext(r_coef[8]);
            r_cnt   <= '0;
            r_state <= S_HID;
          end
        end
        S_HID: begin
          r_cnt <= r_cnt + 3'd1;
          if (!r_cnt[0]) begin
            r_acc <= w_sum;
          end else begin
            r_h[r_cnt[2:1]] <= w_relu;
            r_acc           <= bias_ext(r_coef[w_nb_idx]);
          end
          if (r_cnt == 3'd7) r_state <= S_OUT;
        end
        S_OUT: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt[1:0] == 2'd3) begin
            r_out_sample <= w_sat8;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        default: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef DECODER_SAT_CNT_EN
  logic [7:0] r_sat_count;
  // only the final output clamp counts; hidden clamps share w_hi/w_lo but are masked by state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if ((r_state == S_OUT) && (r_cnt[1:0] == 2'd3) && (w_hi || w_lo)
                 && (r_sat_count != 8'hFF)) begin
      r_sat_count <= r_sat_count + 8'd1;
    end
  end
  assign sat_count = r_sat_count;
`endif

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;

endmodule

// File: doc/feature_decoder.md
# feature_decoder

Time-multiplexed decoder stage that consumes the two compressed features produced by the encoder and reconstructs one denoised 8-bit audio sample. It evaluates a 2→4 hidden layer with ReLU, then a 4→1 linear output layer, on a single shared signed 8×8 multiply-accumulate unit under a small FSM. Trained weights are loaded through a register-write port. Input and output use valid/ready handshakes.

## Interface
- FRAC, 6, fractional bits of weights (Q1.FRAC); products are arithmetic-shifted right by FRAC.
- ACC_W, 20, accumulator width in bits.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  feature pair valid.
- in_ready  out  1  block can accept a feature pair.
- feature0  in  8  signed feature 0 from the encoder.
- feature1  in  8  signed feature 1 from the encoder.
- out_valid  out  1  reconstructed sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_sample  out  8  signed reconstructed sample.
- wr_en  in  1  coefficient write strobe.
- wr_addr  in  5  coefficient address.
- wr_data  in  8  signed coefficient value.
- busy  out  1  high in any state other than IDLE.
- sat_count  out  8  saturation event counter (only with DECODER_SAT_CNT_EN).

## Operation
- Coefficient map:
  - 0–7: w3[j][k] at address 2j+k (j = hidden neuron 0..3, k = feature 0..1).
  - 8–11: b3[j].
  - 12–15: w4[j].
  - 16: b4.
  - Writes to addresses 17–31 are ignored.
- wr_en takes effect only while busy=0. It is silently ignored otherwise.
- All coefficients reset to 0.
- Hidden neuron: h[j] = relu(sat8(((b3[j] <<< FRAC) + w3[j][0]*f0 + w3[j][1]*f1) >>> FRAC)).
- Output: y = sat8(((b4 <<< FRAC) + Σ w4[j]*h[j]) >>> FRAC). No ReLU is applied to the output.
- Arithmetic rules:
  - Products are 16-bit signed and sign-extended to ACC_W.
  - Right shift is arithmetic (floor).
  - sat8 clamps to the range [-128, 127].
- FSM states are IDLE, HID, OUT and DONE.
  - **IDLE:** in_ready=1. On in_valid && in_ready, latch feature0 and feature1, load acc with b3[0]<<<FRAC, and go to HID.
  - **HID:** one MAC per cycle, with k toggling 0→1. When k=1, store h[j] computed from acc+product, then reload acc with the next bias. After j=3,k=1, load acc with b4<<<FRAC and go to OUT. This state lasts 8 cycles.
  - **OUT:** one MAC per cycle over j=0..3. When j=3, register out_sample = sat8(...), set out_valid=1, and go to DONE. This state lasts 4 cycles.
  - **DONE:** hold out_valid and out_sample stable until out_valid && out_ready, then clear out_valid and go to IDLE.
- in_ready=0 in HID, OUT and DONE. in_valid is ignored in those states.
- out_sample holds its last value after the handshake.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_sample=0, busy=0, sat_count=0.
  - FSM in IDLE; all coefficients, h[] and acc cleared.
- Latency: input accepted at edge T; out_valid is high after edge T+12.
- Minimum initiation interval is 14 cycles (out_ready held high).
- Reset asserted mid-computation aborts immediately. There is no partial output, and coefficients must be reloaded.
- A coefficient write in the same cycle as an input accept (both in IDLE) is applied. It is visible to that computation if it targets a coefficient read later in the sequence.

## Configuration
- DECODER_SAT_CNT_EN:
  - **Defined:** the sat_count port and counter exist. The counter increments by 1 on each output sample where sat8 clamped the output value (hidden-layer clamps are not counted). It saturates at 255 and is cleared only by reset.
  - **Undefined:** the port and logic are absent, and the datapath is otherwise identical.

## Test plan
- Reset: hold rst_n low with in_valid=1 → in_ready=1, out_valid=0, out_sample=0, busy=0.
- Pass-through: w3[0][0]=64, w4[0]=64, all else 0; feature0=40, feature1=-7 → out_sample=40, out_valid rises exactly 12 cycles after the accept edge.
- ReLU and bias: same weights, feature0=-40 → out_sample=0. Then set b4=10 → out_sample=10.
- Saturation: w3[0][0]=w3[0][1]=127, w4[0]=127, feature0=feature1=127 → h[0]=127, out_sample=127, sat_count=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_sample stable, in_ready=0, in_valid pulses ignored, wr_en writes ignored. Raise out_ready → one handshake, IDLE next cycle.
- Reset mid-HID: drop rst_n 3 cycles after accept → all outputs at reset values, coefficients read back as 0 (the pass-through stimulus yields 0).
